// File: rtl/adpcm_mc_encoder.sv
// Multi-channel IMA ADPCM encoder: per-channel predictor/step-index state,
// single-cycle encode on accept, registered output with valid/ready hold.
module adpcm_mc_encoder #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [15:0]     in_sample,
  input  logic            ch_clear,
  input  logic [CH_W-1:0] ch_clear_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [3:0]      out_code,
  output logic [15:0]     out_pred
);

  function automatic logic [14:0] step_of(input logic [6:0] idx);
    case (idx)
      7'd0:  step_of = 15'd7;     7'd1:  step_of = 15'd8;     7'd2:  step_of = 15'd9;     7'd3:  step_of = 15'd10;
      7'd4:  step_of = 15'd11;    7'd5:  step_of = 15'd12;    7'd6:  step_of = 15'd13;    7'd7:  step_of = 15'd14;
      7'd8:  step_of = 15'd16;    7'd9:  step_of = 15'd17;    7'd10: step_of = 15'd19;    7'd11: step_of = 15'd21;
      7'd12: step_of = 15'd23;    7'd13: step_of = 15'd25;    7'd14: step_of = 15'd28;    7'd15: step_of = 15'd31;
      7'd16: step_of = 15'd34;    7'd17: step_of = 15'd37;    7'd18: step_of = 15'd41;    7'd19: step_of = 15'd45;
      7'd20: step_of = 15'd50;    7'd21: step_of = 15'd55;    7'd22: step_of = 15'd60;    7'd23: step_of = 15'd66;
      7'd24: step_of = 15'd73;    7'd25: step_of = 15'd80;    7'd26: step_of = 15'd88;    7'd27: step_of = 15'd97;
      7'd28: step_of = 15'd107;   7'd29: step_of = 15'd118;   7'd30: step_of = 15'd130;   7'd31: step_of = 15'd143;
      7'd32: step_of = 15'd157;   7'd33: step_of = 15'd173;   7'd34: step_of = 15'd190;   7'd35: step_of = 15'd209;
      7'd36: step_of = 15'd230;   7'd37: step_of = 15'd253;   7'd38: step_of = 15'd279;   7'd39: step_of = 15'd307;
      7'd40: step_of = 15'd337;   7'd41: step_of = 15'd371;   7'd42: step_of = 15'd408;   7'd43: step_of = 15'd449;
      7'd44: step_of = 15'd494;   7'd45: step_of = 15'd544;   7'd46: step_of = 15'd598;   7'd47: step_of = 15'd658;
      7'd48: step_of = 15'd724;   7'd49: step_of = 15'd796;   7'd50: step_of = 15'd876;   7'd51: step_of = 15'd963;
      7'd52: step_of = 15'd1060;  7'd53: step_of = 15'd1166;  7'd54: step_of = 15'd1282;  7'd55: step_of = 15'd1411;
      7'd56: step_of = 15'd1552;  7'd57: step_of = 15'd1707;  7'd58: step_of = 15'd1878;  7'd59: step_of = 15'd2066;
      7'd60: step_of = 15'd2272;  7'd61: step_of = 15'd2499;  7'd62: step_of = 15'd2749;  7'd63: step_of = 15'd3024;
      7'd64: step_of = 15'd3327;  7'd65: step_of = 15'd3660;  7'd66: step_of = 15'd4026;  7'd67: step_of = 15'd4428;
      7'd68: step_of = 15'd4871;  7'd69: step_of = 15'd5358;  7'd70: step_of = 15'd5894;  7'd71: step_of = 15'd6484;
      7'd72: step_of = 15'd7132;  7'd73: step_of = 15'd7845;  7'd74: step_of = 15'd8630;  7'd75: step_of = 15'd9493;
      7'd76: step_of = 15'd10442; 7'd77: step_of = 15'd11487; 7'd78: step_of = 15'd12635; 7'd79: step_of = 15'd13899;
      7'd80: step_of = 15'd15289; 7'd81: step_of = 15'd16818; 7'd82: step_of = 15'd18500; 7'd83: step_of = 15'd20350;
      7'd84: step_of = 15'd22385; 7'd85: step_of = 15'd24623; 7'd86: step_of = 15'd27086; 7'd87: step_of = 15'd29794;
      default: step_of = 15'd32767;
    endcase
  endfunction

  function automatic logic signed [7:0] idx_adj(input logic [2:0] mag_code);
    case (mag_code)
      3'd4:    idx_adj = 8'sd2;
      3'd5:    idx_adj = 8'sd4;
      3'd6:    idx_adj = 8'sd6;
      3'd7:    idx_adj = 8'sd8;
      default: idx_adj = -8'sd1;
    endcase
  endfunction

  logic signed [15:0] pred_q [CHANNELS];
  logic [6:0]         idx_q  [CHANNELS];
  logic               out_valid_q;
  logic [CH_W-1:0]    out_ch_q;
  logic [3:0]         out_code_q;
  logic [15:0]        out_pred_q;

  logic               accept, ch_ok, clr_ok;
  logic [CH_W-1:0]    sel;
  logic signed [15:0] pred_cur;
  logic [6:0]         idx_cur;
  logic [14:0]        step;
  logic signed [16:0] diff;
  logic [16:0]        mag, rem1, rem2, vpdiff;
  logic signed [17:0] sum;
  logic signed [7:0]  idx_sum;
  logic [3:0]         code_d;
  logic [15:0]        pred_d;
  logic [6:0]         idx_d;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign ch_ok     = 32'(in_ch) < CHANNELS;
  assign clr_ok    = 32'(ch_clear_id) < CHANNELS;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_code  = out_code_q;
  assign out_pred  = out_pred_q;

  always_comb begin
    sel      = ch_ok ? in_ch : '0;
    pred_cur = pred_q[sel];
    idx_cur  = idx_q[sel];
    step     = step_of(idx_cur);
    diff     = $signed({in_sample[15], in_sample}) - $signed({pred_cur[15], pred_cur});
    code_d   = '0;
    code_d[3] = diff[16];
    mag      = diff[16] ? 17'(-diff) : 17'(diff);
    rem1     = mag;
    if (mag >= {2'b0, step}) begin
      code_d[2] = 1'b1;
      rem1      = mag - {2'b0, step};
    end
    rem2 = rem1;
    if (rem1 >= {3'b0, step[14:1]}) begin
      code_d[1] = 1'b1;
      rem2      = rem1 - {3'b0, step[14:1]};
    end
    code_d[0] = rem2 >= {4'b0, step[14:2]};
    vpdiff = {5'b0, step[14:3]}
           + (code_d[2] ? {2'b0, step}       : 17'd0)
           + (code_d[1] ? {3'b0, step[14:1]} : 17'd0)
           + (code_d[0] ? {4'b0, step[14:2]} : 17'd0);
    sum = code_d[3] ? ($signed({{2{pred_cur[15]}}, pred_cur}) - $signed({1'b0, vpdiff}))
                    : ($signed({{2{pred_cur[15]}}, pred_cur}) + $signed({1'b0, vpdiff}));
    // Out of 16-bit range whenever the top three bits disagree
    if (sum[17:15] != {3{sum[17]}}) pred_d = sum[17] ? 16'h8000 : 16'h7FFF;
    else                            pred_d = sum[15:0];
    idx_sum = $signed({1'b0, idx_cur}) + idx_adj(code_d[2:0]);
    if (idx_sum[7])                idx_d = '0;
    else if (idx_sum > 8'sd88)     idx_d = 7'd88;
    else                           idx_d = idx_sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pred_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_code_q  <= '0;
      out_pred_q  <= '0;
    end else begin
      if (accept && ch_ok) begin
        pred_q[sel] <= pred_d;
        idx_q[sel]  <= idx_d;
      end
      // Placed after the encode write so a coincident clear wins the state
      if (ch_clear && clr_ok) begin
        pred_q[ch_clear_id] <= '0;
        idx_q[ch_clear_id]  <= '0;
      end
      if (accept && ch_ok) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= in_ch;
        out_code_q  <= code_d;
        out_pred_q  <= pred_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adpcm_mc_encoder.sv
// Bench for adpcm_mc_encoder: integer reference model plus output queue checked
// every cycle, and literal expectations on hand-derived points.
module tb_adpcm_mc_encoder;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned CH_W     = 1;

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, ch_clear, out_valid, out_ready;
  logic [CH_W-1:0] in_ch, ch_clear_id, out_ch;
  logic [15:0]     in_sample, out_pred;
  logic [3:0]      out_code;
  bit              mon_en = 1'b0;
  int              vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  adpcm_mc_encoder #(.CHANNELS(CHANNELS), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_sample(in_sample), .ch_clear(ch_clear),
    .ch_clear_id(ch_clear_id), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_code(out_code), .out_pred(out_pred)
  );

  int step_tab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};

  typedef struct { int ch; int code; int pred; } exp_t;
  int   m_pred [CHANNELS];
  int   m_idx  [CHANNELS];
  exp_t q [$];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endfunction

  function automatic exp_t encode(int ch, int s);
    int   p, ix, st, d, c, vp;
    int   adj [8];
    exp_t e;
    adj = '{-1, -1, -1, -1, 2, 4, 6, 8};
    p  = m_pred[ch];
    ix = m_idx[ch];
    st = step_tab[ix];
    d  = s - p;
    c  = 0;
    if (d < 0) begin c = 8; d = -d; end
    vp = st / 8;
    if (d >= st)     begin c += 4; d -= st;     vp += st;     end
    if (d >= st / 2) begin c += 2; d -= st / 2; vp += st / 2; end
    if (d >= st / 4) begin c += 1;              vp += st / 4; end
    p = (c >= 8) ? p - vp : p + vp;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    ix += adj[c % 8];
    if (ix < 0)  ix = 0;
    if (ix > 88) ix = 88;
    m_pred[ch] = p;
    m_idx[ch]  = ix;
    e.ch = ch; e.code = c; e.pred = p;
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    bit exp_ready;
    if (mon_en) begin
      exp_ready = (q.size() == 0) || out_ready;
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      if (q.size() != 0) begin
        check("out_valid", {31'b0, out_valid}, 32'd1);
        check("out_ch",    {31'b0, out_ch},    q[0].ch);
        check("out_code",  {28'b0, out_code},  q[0].code);
        check("out_pred",  {{16{out_pred[15]}}, out_pred}, q[0].pred);
        if (out_ready) void'(q.pop_front());
      end else begin
        check("out_valid", {31'b0, out_valid}, 32'd0);
      end
      if (reset) begin
        q.delete();
        foreach (m_pred[i]) begin m_pred[i] = 0; m_idx[i] = 0; end
      end else begin
        if (in_valid && exp_ready && int'(in_ch) < CHANNELS)
          q.push_back(encode(int'(in_ch), int'($signed(in_sample))));
        if (ch_clear && int'(ch_clear_id) < CHANNELS) begin
          m_pred[ch_clear_id] = 0;
          m_idx[ch_clear_id]  = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string name, logic [3:0] code, logic [15:0] pred);
    check({name, "_code"}, {28'b0, out_code}, {28'b0, code});
    check({name, "_pred"}, {16'b0, out_pred}, {16'b0, pred});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_sample = '0;
    ch_clear = 1'b0; ch_clear_id = '0; out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    lit("rst", 4'h0, 16'h0000);

    // Two ch0 samples of 0x0100 from reset state
    in_valid = 1'b1; in_ch = 1'b0; in_sample = 16'h0100;
    tick(); lit("ch0_first", 4'h7, 16'h000B);
    tick(); lit("ch0_second", 4'h7, 16'h0029);
    in_valid = 1'b0;
    tick();

    // Negative sample on ch1, clear, then lower index clamp
    do_reset();
    in_valid = 1'b1; in_ch = 1'b1; in_sample = 16'hFF00;
    tick(); lit("ch1_neg", 4'hF, 16'hFFF5);
    in_valid = 1'b0; ch_clear = 1'b1; ch_clear_id = 1'b1;
    tick();
    ch_clear = 1'b0; in_valid = 1'b1; in_sample = 16'h0000;
    tick(); lit("ch1_zero", 4'h0, 16'h0000);
    in_sample = 16'h0100;
    tick(); lit("ch1_clamp", 4'h7, 16'h000B);
    in_valid = 1'b0;

    // Interleaved channels, no bubbles
    do_reset();
    in_valid = 1'b1; in_sample = 16'h0100;
    in_ch = 1'b0; tick(); lit("il0", 4'h7, 16'h000B);
    in_ch = 1'b1; tick(); lit("il1", 4'h7, 16'h000B);
    check("il1_ch", {31'b0, out_ch}, 32'd1);
    in_ch = 1'b0; tick(); lit("il2", 4'h7, 16'h0029);
    in_valid = 1'b0;

    // Positive full-scale run, then a zero sample after index has decayed to 0
    do_reset();
    in_valid = 1'b1; in_ch = 1'b0; in_sample = 16'h7FFF;
    for (int i = 0; i < 100; i++) tick();
    check("sat_hi", {16'b0, out_pred}, 32'h7FFF);
    in_sample = 16'h0000;
    tick(); lit("sat_hi_after", 4'hF, 16'h7FF4);
    in_sample = 16'h8000;
    for (int i = 0; i < 100; i++) tick();
    in_ch = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_sample = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: stall, hold, release
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 1'b0; in_sample = 16'h0100;
    tick();
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    lit("bp_held0", 4'h7, 16'h000B);
    in_sample = 16'h0200;
    tick(); tick();
    lit("bp_held2", 4'h7, 16'h000B);
    out_ready = 1'b1;
    tick(); lit("bp_resume", 4'h7, 16'h0029);
    in_valid = 1'b0;
    tick();
    check("bp_drain", {31'b0, out_valid}, 32'd0);

    // Clear coincident with accept on the same channel
    do_reset();
    in_valid = 1'b1; in_ch = 1'b0; in_sample = 16'h0100;
    ch_clear = 1'b1; ch_clear_id = 1'b0;
    tick(); ch_clear = 1'b0;
    lit("clr_same", 4'h7, 16'h000B);
    tick(); lit("clr_next", 4'h7, 16'h000B);
    in_valid = 1'b0;

    // Reset while output pending
    out_ready = 1'b0;
    in_valid = 1'b1; in_ch = 1'b1; in_sample = 16'h0100;
    tick();
    in_valid = 1'b0;
    check("pend_valid", {31'b0, out_valid}, 32'd1);
    do_reset();
    check("rst_drop", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adpcm_mc_encoder.md
# adpcm_mc_encoder

Multi-channel IMA ADPCM encoder: compresses signed 16-bit PCM samples to 4-bit codes for up to CHANNELS interleaved streams, each with its own predictor and step-index state. It generalises the single-stream encoder by adding a channel tag, valid/ready flow control on both sides, and per-channel state clear. It also returns the reconstructed sample, bit-exact with what the matching decoder produces for the same code sequence.

## Interface
- CHANNELS, default 2: number of independent streams (1..256).
- CH_W, default $clog2(CHANNELS) (minimum 1): channel tag width.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all channel state and the output register.
- in_valid  in  1  sample offered.
- in_ready  out  1  encoder can accept this cycle.
- in_ch  in  CH_W  channel tag of offered sample.
- in_sample  in  16  signed two's-complement PCM sample.
- ch_clear  in  1  one-cycle request to reset one channel's state.
- ch_clear_id  in  CH_W  channel to clear.
- out_valid  out  1  code available.
- out_ready  in  1  consumer takes code this cycle.
- out_ch  out  CH_W  channel tag of code.
- out_code  out  4  ADPCM code {sign, b2, b1, b0}.
- out_pred  out  16  reconstructed sample after update (signed).

## Operation
- Per-channel state: pred (signed 16, reset 0), index (7 bits, 0..88, reset 0).
- Tables: standard 89-entry IMA step table (7..32767); index adjust {-1,-1,-1,-1,2,4,6,8} by code[2:0].
- Accept occurs when in_valid && in_ready. Encoding on the accept cycle, using current state of in_ch:
  - step = step_tab[index]; diff = sample - pred, 17-bit signed.
  - code[3] = diff < 0; diff = |diff|.
  - if diff >= step: code[2]=1, diff -= step; if diff >= step>>1: code[1]=1, diff -= step>>1; if diff >= step>>2: code[0]=1.
  - vpdiff = (step>>3) + (code[2]?step:0) + (code[1]?step>>1:0) + (code[0]?step>>2:0).
  - pred' = pred ± vpdiff (minus when code[3]), computed 18-bit, saturated to [-32768, 32767].
  - index' = index + adjust, saturated to [0, 88].
- State for in_ch written with pred'/index'; out_ch/out_code/out_pred registered from the same computation.
- in_ch >= CHANNELS: accepted (in_ready unchanged), discarded, no state change, no output.
- ch_clear: ch_clear_id state set to pred=0, index=0 at the clock edge; independent of handshake.
- ch_clear to same channel as an accept in the same cycle: encoding uses pre-clear state, output emitted normally, channel ends with reset values (clear wins the state write).
- Channels fully isolated; arbitrary interleaving and back-to-back same-channel samples are legal with no bubbles.

## Timing
- Reset values: out_valid=0, out_ch=0, out_code=0, out_pred=0, in_ready=1; all channel state pred=0, index=0.
- in_ready = !out_valid || out_ready (combinational from out_ready).
- Latency: code for a sample accepted at edge N is valid after edge N (out_valid=1 in cycle N+1).
- Throughput: one sample per cycle while out_ready=1.
- out_valid, out_ch, out_code, out_pred held stable while out_valid && !out_ready.
- out_valid falls after a cycle with out_ready=1 and no new accept.
- Reset asserted mid-stream: pending output dropped, all state cleared at that edge; reset dominates ch_clear and accepts.

## Test plan
- After reset, ch0 sample 0x0100 -> out_code 0x7, out_pred 0x000B, ch0 index 8; second ch0 0x0100 -> out_code 0x7, out_pred 0x0029, index 16.
- After reset, ch1 sample 0xFF00 -> out_code 0xF, out_pred 0xFFF5; then ch1 sample 0x0000 from reset state after ch_clear on ch1 -> out_code 0x0, out_pred 0x0000, index stays 0 (lower clamp).
- Interleave ch0 0x0100, ch1 0x0100, ch0 0x0100 back-to-back -> codes 0x7,0x7,0x7; preds 0x000B, 0x000B, 0x0029 (isolation, no bubbles).
- 100 consecutive ch0 samples 0x7FFF -> out_pred never wraps, reaches and holds 0x7FFF, index saturates at 88; same with 0x8000 -> holds 0x8000.
- Hold out_ready=0 with in_valid=1 -> one accept, in_ready=0 next cycle, outputs stable; release -> stream resumes without loss or duplication.
- ch_clear on ch0 coincident with ch0 accept -> output uses old state, next ch0 sample encodes from pred=0/index=0; reset asserted while out_valid=1 -> out_valid=0 next cycle.
